regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between two writeback sources (ALU, MEM).

---
 rtl/regfile_pkg.sv | 11 +
 rtl/rr_arb2.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and writeback-source encoding for the regfile writeback arbiter.
package regfile_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is ALU, bit 1 is MEM.
import regfile_pkg::*;

module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       xfer,
  output logic [1:0] grant,
  output wb_src_e    last_grant
);

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      valid[0] && (!valid[1] || last_grant == SRC_MEM): grant = 2'b01;
      valid[1] && (!valid[0] || last_grant == SRC_ALU): grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset to MEM so the ALU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SRC_MEM;
    end else if (xfer) begin
      last_grant <= grant[0] ? SRC_ALU : SRC_MEM;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and MEM writeback, with a pending scoreboard.
// Optional write-to-read bypass is enabled by defining REGFILE_WB_BYPASS_EN.
import regfile_pkg::*;

module regfile_wb_arbiter #(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int NREGS  = regfile_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic [ADDR_W-1:0] rd_reg1,
  input  logic [ADDR_W-1:0] rd_reg2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data1,
  output logic [DATA_W-1:0] byp_data2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  logic [1:0]       grant;
  wb_src_e          last_grant;
  logic             alu_xfer;
  logic             mem_xfer;
  logic [NREGS-1:0] pending;

  // Ready is suppressed while reset is held so nothing is accepted.
  assign alu_ready = rst_n && grant[0];
  assign mem_ready = rst_n && grant[1];
  assign alu_xfer  = alu_valid && alu_ready;
  assign mem_xfer  = mem_valid && mem_ready;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      ({mem_valid, alu_valid}),
    .xfer       (alu_xfer || mem_xfer),
    .grant      (grant),
    .last_grant (last_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (alu_xfer) begin
      rf_we    <= (alu_reg != '0);
      rf_waddr <= alu_reg;
      rf_wdata <= alu_data;
    end else if (mem_xfer) begin
      rf_we    <= (mem_reg != '0);
      rf_waddr <= mem_reg;
      rf_wdata <= mem_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Set beats clear when an issue and a retiring write hit the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending[0] <= 1'b0;
      for (int i = 1; i < NREGS; i++) begin
        pending[i] <= (issue_valid && issue_reg == ADDR_W'(i)) ||
                      (pending[i] && !(rf_we && rf_waddr == ADDR_W'(i)));
      end
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign byp_hit1  = rf_we && rf_waddr == rd_reg1 && rd_reg1 != '0;
  assign byp_hit2  = rf_we && rf_waddr == rd_reg2 && rd_reg2 != '0;
  assign byp_data1 = rf_wdata;
  assign byp_data2 = rf_wdata;
`else
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data1 = '0;
  assign byp_data2 = '0;
`endif

  assign rd_busy1 = (rd_reg1 != '0) && pending[rd_reg1] && !byp_hit1;
  assign rd_busy2 = (rd_reg2 != '0) && pending[rd_reg2] && !byp_hit2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Expectations follow REGFILE_WB_BYPASS_EN when it is defined.
module tb_regfile_wb_arbiter;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic [4:0]  rd_reg1;
  logic [4:0]  rd_reg2;
  logic        rd_busy1;
  logic        rd_busy2;
  logic        byp_hit1;
  logic        byp_hit2;
  logic [31:0] byp_data1;
  logic [31:0] byp_data2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_reg     (alu_reg),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_reg     (mem_reg),
    .mem_data    (mem_data),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .rd_reg1     (rd_reg1),
    .rd_reg2     (rd_reg2),
    .rd_busy1    (rd_busy1),
    .rd_busy2    (rd_busy2),
    .byp_hit1    (byp_hit1),
    .byp_hit2    (byp_hit2),
    .byp_data1   (byp_data1),
    .byp_data2   (byp_data2),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_reg = 5'd4; mem_data = 32'h22;
    issue_valid = 1'b0; issue_reg = 5'd0;
    rd_reg1 = 5'd3; rd_reg2 = 5'd4;
    repeat (3) step();
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_wr: we=%b addr=%0d data=%h want 0/0/0", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: alu=%b mem=%b want 0/0", alu_ready, mem_ready);
    end
    checks++;
    if (rd_busy1 !== 1'b0 || rd_busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: b1=%b b2=%b want 0/0", rd_busy1, rd_busy2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL first_tie: alu=%b mem=%b want 1/0", alu_ready, mem_ready);
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    step();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL idle_we: we=%b want 0", rf_we);
    end
  endtask

  task automatic test_tie();
    @(negedge clk);
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_reg = 5'd4; mem_data = 32'h22;
    #1;
    checks++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL tie_g1: alu=%b mem=%b want 1/0", alu_ready, mem_ready);
    end
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin
      errors++;
      $display("FAIL tie_w1: we=%b addr=%0d data=%h want 1/3/11", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL tie_g2: alu=%b mem=%b want 0/1", alu_ready, mem_ready);
    end
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h22) begin
      errors++;
      $display("FAIL tie_w2: we=%b addr=%0d data=%h want 1/4/22", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL tie_g3: alu=%b mem=%b want 1/0", alu_ready, mem_ready);
    end
    @(negedge clk);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    step();
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd4 || rf_wdata !== 32'h22) begin
      errors++;
      $display("FAIL tie_hold: we=%b addr=%0d data=%h want 0/4/22", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFF;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready: alu_ready=%b want 1", alu_ready);
    end
    step();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL zero_we: we=%b want 0", rf_we);
    end
    @(negedge clk);
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_reg = 5'd0; rd_reg1 = 5'd0;
    step();
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    checks++;
    if (rd_busy1 !== 1'b0) begin
      errors++;
      $display("FAIL zero_busy: busy1=%b want 0", rd_busy1);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    issue_valid = 1'b1; issue_reg = 5'd5; rd_reg1 = 5'd5; rd_reg2 = 5'd6;
    #1;
    checks++;
    if (rd_busy1 !== 1'b0) begin
      errors++;
      $display("FAIL sb_early: busy1=%b want 0", rd_busy1);
    end
    step();
    checks++;
    if (rd_busy1 !== 1'b1 || rd_busy2 !== 1'b0) begin
      errors++;
      $display("FAIL sb_set: b1=%b b2=%b want 1/0", rd_busy1, rd_busy2);
    end
    @(negedge clk);
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_reg = 5'd5; mem_data = 32'h55;
    #1;
    checks++;
    if (mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL sb_mready: mem_ready=%b want 1", mem_ready);
    end
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rd_busy1 !== !BYP) begin
      errors++;
      $display("FAIL sb_wr: we=%b addr=%0d busy1=%b want 1/5/%b", rf_we, rf_waddr, rd_busy1, !BYP);
    end
    @(negedge clk);
    mem_valid = 1'b0;
    step();
    checks++;
    if (rd_busy1 !== 1'b0) begin
      errors++;
      $display("FAIL sb_clear: busy1=%b want 0", rd_busy1);
    end
    @(negedge clk);
    issue_valid = 1'b1;
    step();
    @(negedge clk);
    issue_valid = 1'b0;
    mem_valid = 1'b1;
    step();
    @(negedge clk);
    mem_valid = 1'b0;
    issue_valid = 1'b1;
    step();
    @(negedge clk);
    issue_valid = 1'b0;
    step();
    checks++;
    if (rd_busy1 !== 1'b1) begin
      errors++;
      $display("FAIL sb_set_wins: busy1=%b want 1", rd_busy1);
    end
    @(negedge clk);
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h0;
    step();
    @(negedge clk);
    alu_valid = 1'b0;
    step();
    checks++;
    if (rd_busy1 !== 1'b0) begin
      errors++;
      $display("FAIL sb_drain: busy1=%b want 0", rd_busy1);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    issue_valid = 1'b1; issue_reg = 5'd7; rd_reg2 = 5'd7;
    step();
    @(negedge clk);
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'hABCD;
    step();
    checks++;
    if (rf_we !== 1'b1 || byp_hit2 !== BYP) begin
      errors++;
      $display("FAIL byp_hit: we=%b hit2=%b want 1/%b", rf_we, byp_hit2, BYP);
    end
    checks++;
    if (byp_data2 !== (BYP ? 32'hABCD : 32'h0) || rd_busy2 !== !BYP) begin
      errors++;
      $display("FAIL byp_data: data2=%h busy2=%b want %h/%b",
               byp_data2, rd_busy2, (BYP ? 32'hABCD : 32'h0), !BYP);
    end
    @(negedge clk);
    alu_valid = 1'b0;
    step();
    checks++;
    if (byp_hit2 !== 1'b0 || rd_busy2 !== 1'b0) begin
      errors++;
      $display("FAIL byp_after: hit2=%b busy2=%b want 0/0", byp_hit2, rd_busy2);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    @(negedge clk);
    issue_valid = 1'b1; issue_reg = 5'd9; rd_reg1 = 5'd9;
    step();
    @(negedge clk);
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_reg = 5'd9; mem_data = 32'h99;
    #1;
    checks++;
    if (mem_ready !== 1'b1 || rd_busy1 !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: ready=%b busy1=%b want 1/1", mem_ready, rd_busy1);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_ready !== 1'b0 || rd_busy1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: ready=%b busy1=%b want 0/0", mem_ready, rd_busy1);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (rf_we !== 1'b0) pulses++;
    end
    @(negedge clk);
    mem_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      if (rf_we !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL mid_we: rf_we pulses=%0d want 0", pulses);
    end
    checks++;
    if (rd_busy1 !== 1'b0 || rf_waddr !== 5'd0) begin
      errors++;
      $display("FAIL mid_post: busy1=%b addr=%0d want 0/0", rd_busy1, rf_waddr);
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_zero_reg();
    test_scoreboard();
    test_bypass();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
